// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    FIR_IDLE = 2'd0,
    FIR_MAC  = 2'd1,
    FIR_DONE = 2'd2
  } fir_state_t;

  // Full-precision accumulator: 2N-bit products plus growth for DELAYS+1 terms.
  function automatic int fir_acc_w(input int n, input int delays);
    return 2 * n + $clog2(delays + 1);
  endfunction

  function automatic int fir_tap_w(input int delays);
    return (delays < 1) ? 1 : $clog2(delays + 1);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
  parameter int N  = 32,
  parameter int AW = 66
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [N-1:0]  a,
  input  logic signed [N-1:0]  c,
  output logic signed [AW-1:0] acc
);

  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  prod_ext;

  assign prod     = (2*N)'(a) * (2*N)'(c);
  assign prod_ext = AW'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR scheduler sharing one multiplier across DELAYS+1 taps per sample.
// Optional FIR_SAT_EN: saturate the output instead of wrapping it.
//
// state    | meaning
// FIR_IDLE | waiting for an accepted sample strobe
// FIR_MAC  | one tap per clock accumulated into acc
// FIR_DONE | acc final; y_out/y_valid update on the next edge
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N      = 32,
  parameter int DELAYS = 3,
  parameter int FRAC   = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_d,
  input  logic                       ena,
  input  logic signed [N-1:0]        x_in,
  input  logic [(DELAYS+1)*N-1:0]    b,
  output logic signed [N-1:0]        y_out,
  output logic                       y_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW = fir_acc_w(N, DELAYS);
  localparam int TW = fir_tap_w(DELAYS);

`ifdef FIR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  fir_state_t          state;
  logic signed [N-1:0] x_dly [DELAYS+1];
  logic signed [N-1:0] coef  [DELAYS+1];
  logic [TW-1:0]       tap_idx;
  logic                accept;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_shr;
  logic                in_range;
  logic signed [N-1:0] result;

  assign accept = clk_d && ena && (state == FIR_IDLE);
  assign busy   = (state != FIR_IDLE);

  fir_mac #(
    .N  (N),
    .AW (AW)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state == FIR_MAC),
    .a   (x_dly[tap_idx]),
    .c   (coef[tap_idx]),
    .acc (acc)
  );

  // In range when every bit above the N-bit result matches its sign bit.
  assign acc_shr  = acc >>> FRAC;
  assign in_range = (&acc_shr[AW-1:N-1]) | ~(|acc_shr[AW-1:N-1]);

  always_comb begin
    result = acc_shr[N-1:0];
    if (SAT_EN && !in_range) begin
      result = acc_shr[AW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FIR_IDLE;
      tap_idx <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (clk_d && ena && (state != FIR_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        FIR_IDLE: begin
          if (accept) begin
            tap_idx <= '0;
            state   <= FIR_MAC;
          end
        end
        FIR_MAC: begin
          tap_idx <= tap_idx + TW'(1);
          if (tap_idx == TW'(DELAYS)) begin
            state <= FIR_DONE;
          end
        end
        FIR_DONE: begin
          y_out   <= result;
          y_valid <= 1'b1;
          state   <= FIR_IDLE;
        end
        default: state <= FIR_IDLE;
      endcase
    end
  end

  // Delay line and coefficient shadow only move on an accepted strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= DELAYS; k++) begin
        x_dly[k] <= '0;
        coef[k]  <= '0;
      end
    end else if (accept) begin
      x_dly[0] <= x_in;
      for (int k = 1; k <= DELAYS; k++) begin
        x_dly[k] <= x_dly[k-1];
      end
      for (int k = 0; k <= DELAYS; k++) begin
        coef[k] <= b[k*N +: N];
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a plain-arithmetic FIR model.
module tb_fir_mac_sequencer;

  localparam int N    = 32;
  localparam int D    = 3;
  localparam int FRAC = 0;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_d;
  logic         ena;
  logic [31:0]  x_in;
  logic [127:0] b;
  logic [31:0]  y_out;
  logic         y_valid;
  logic         busy;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  logic signed [31:0] m_x [4];
  logic signed [31:0] m_c [4];

  fir_mac_sequencer #(.N(N), .DELAYS(D), .FRAC(FRAC)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_d   (clk_d),
    .ena     (ena),
    .x_in    (x_in),
    .b       (b),
    .y_out   (y_out),
    .y_valid (y_valid),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_y();
    logic signed [127:0] s, p, q;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      p = m_x[k];
      q = m_c[k];
      s = s + p * q;
    end
    s = s >>> FRAC;
`ifdef FIR_SAT_EN
    if (s > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (s < -128'sh80000000) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic model_accept(input logic [31:0] x);
    for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = x;
    for (int k = 0; k < 4; k++) m_c[k] = b[k*32 +: 32];
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_x[k] = '0;
      m_c[k] = '0;
    end
  endtask

  task automatic wait_valid(input string name, output logic [31:0] yo, output int lat);
    lat = 1;
    while (!y_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (y_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: y_valid got %b after %0d cycles, required 1", name, y_valid, lat);
    end
    yo = y_out;
  endtask

  task automatic do_sample(input logic [31:0] x, input string name, output logic [31:0] yo);
    logic [31:0] expv;
    int lat;
    model_accept(x);
    expv = model_y();
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = x;
    @(negedge clk);
    clk_d = 1'b0;
    wait_valid(name, yo, lat);
    checks++;
    if (lat !== D + 3) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, D + 3);
    end
    checks++;
    if (yo !== expv) begin
      errors++;
      $display("FAIL %s y_out: got %h required %h", name, yo, expv);
    end
    @(negedge clk);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s y_valid width: got %b required 0", name, y_valid);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (y_out !== 32'd0) begin errors++; $display("FAIL reset y_out: got %h required 0", y_out); end
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset y_valid: got %b required 0", y_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun: got %b required 0", overrun); end
  endtask

  task automatic test_impulse(input string name);
    logic [31:0] exp_c [5];
    logic [31:0] yo;
    exp_c[0] = 32'd193000; exp_c[1] = 32'd376000; exp_c[2] = 32'd376000;
    exp_c[3] = 32'd193000; exp_c[4] = 32'd0;
    b = {32'd193, 32'd376, 32'd376, 32'd193};
    for (int i = 0; i < 5; i++) begin
      do_sample((i == 0) ? 32'd1000 : 32'd0, name, yo);
      checks++;
      if (yo !== exp_c[i]) begin
        errors++;
        $display("FAIL %s step %0d: got %0d required %0d", name, i, yo, exp_c[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] yo;
    for (int i = 0; i < 8; i++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      do_sample($urandom, "random", yo);
    end
  endtask

  task automatic test_ena_gating();
    logic [31:0] yo;
    bit bad;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bad = 1'b0;
      @(negedge clk);
      clk_d = 1'b1;
      x_in  = 32'd500;
      @(negedge clk);
      clk_d = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (y_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL ena_gating strobe %0d: got activity (valid/busy/overrun) required none", i);
      end
    end
    ena = 1'b1;
    b = {$urandom, $urandom, $urandom, $urandom};
    do_sample($urandom, "ena_resume", yo);
  endtask

  task automatic test_coef_swap();
    logic [31:0] expv, yo;
    int lat;
    b = {$urandom, $urandom, $urandom, $urandom};
    model_accept($urandom);
    expv = model_y();
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = m_x[0];
    @(negedge clk);
    clk_d = 1'b0;
    @(negedge clk);
    b = {$urandom, $urandom, $urandom, $urandom};
    wait_valid("coef_swap_old", yo, lat);
    checks++;
    if (yo !== expv) begin
      errors++;
      $display("FAIL coef_swap_old y_out: got %h required %h", yo, expv);
    end
    do_sample($urandom, "coef_swap_new", yo);
  endtask

  task automatic test_saturation();
    logic [31:0] yo, expv;
`ifdef FIR_SAT_EN
    expv = 32'h7FFFFFFF;
`else
    expv = 32'hFFFFFFFE;
`endif
    b = {32'd0, 32'd0, 32'd0, 32'd2};
    do_sample(32'h7FFFFFFF, "saturation", yo);
    checks++;
    if (yo !== expv) begin
      errors++;
      $display("FAIL saturation const: got %h required %h", yo, expv);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] expv, yo;
    int lat;
    b = {$urandom, $urandom, $urandom, $urandom};
    model_accept($urandom);
    expv = model_y();
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = m_x[0];
    @(negedge clk);
    clk_d = 1'b0;
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = $urandom;
    @(negedge clk);
    clk_d = 1'b0;
    wait_valid("overrun", yo, lat);
    checks++;
    if (yo !== expv) begin
      errors++;
      $display("FAIL overrun y_out: got %h required %h", yo, expv);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun flag: got %b required 1", overrun);
    end
    @(negedge clk);
    do_sample($urandom, "overrun_next", yo);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_rst_midop();
    bit seen;
    b = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = $urandom;
    @(negedge clk);
    clk_d = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (y_out !== 32'd0) begin errors++; $display("FAIL rst_midop y_out: got %h required 0", y_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_midop busy: got %b required 0", busy); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_midop overrun: got %b required 0", overrun); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (y_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_midop y_valid: got 1 required 0"); end
    test_impulse("impulse_after_rst");
  endtask

  task automatic test_done_collision();
    logic [31:0] expv, yo;
    int lat;
    b = {$urandom, $urandom, $urandom, $urandom};
    model_accept($urandom);
    expv = model_y();
    @(negedge clk);
    clk_d = 1'b1;
    x_in  = m_x[0];
    @(negedge clk);
    clk_d = 1'b0;
    repeat (D + 1) @(negedge clk);
    clk_d = 1'b1;
    x_in  = $urandom;
    @(negedge clk);
    clk_d = 1'b0;
    wait_valid("done_collision", yo, lat);
    checks++;
    if (yo !== expv) begin
      errors++;
      $display("FAIL done_collision y_out: got %h required %h", yo, expv);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL done_collision overrun: got %b required 1", overrun);
    end
    @(negedge clk);
    do_sample($urandom, "done_collision_next", yo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    clk_d = 1'b0;
    ena   = 1'b1;
    x_in  = '0;
    b     = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_impulse("impulse");
    test_random();
    test_ena_gating();
    test_coef_swap();
    test_saturation();
    test_overrun();
    test_rst_midop();
    test_done_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
